// File: rtl/mem_responder.sv
// Memory-side responder for the unified instruction/data port.
// Word-addressed RAM with a fixed number of wait states per access.
module mem_responder #(
  parameter int DEPTH_LOG2 = 6,
  parameter int WAIT       = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] LP_LOAD =
    (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAITING = 2'd1,
    S_RESP    = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;
  logic        w_accept;

  logic        r_we;
  logic [31:0] r_adr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;

  logic [31:0] r_ram [DEPTH];

  logic        w_enter;
  logic        w_sel_we;
  logic [31:0] w_sel_adr;
  logic [31:0] w_sel_wdata;
  logic        w_valid;
  logic        w_commit;
  logic [DEPTH_LOG2-1:0] w_idx;

  // Next state and wait counter; requests only accepted in IDLE
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_accept   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (req) begin
          w_accept = 1'b1;
          if (WAIT > 0) begin
            w_next     = S_WAITING;
            w_cnt_next = LP_LOAD;
          end else begin
            w_next = S_RESP;
          end
        end
      end
      S_WAITING: begin
        if (r_cnt == 4'd0) begin
          w_next = S_RESP;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // With no wait states the request is still on the inputs
  // at the edge that enters RESP, so bypass the latches.
  assign w_sel_we    = (r_state == S_IDLE) ? we    : r_we;
  assign w_sel_adr   = (r_state == S_IDLE) ? adr   : r_adr;
  assign w_sel_wdata = (r_state == S_IDLE) ? wdata : r_wdata;

  assign w_enter = (w_next == S_RESP) && (r_state != S_RESP);
  assign w_valid = (w_sel_adr[1:0] == 2'b00) &&
    ((w_sel_adr >> (DEPTH_LOG2 + 2)) == 32'd0);
  assign w_idx   = w_sel_adr[DEPTH_LOG2+1:2];
  assign w_commit = w_enter && w_valid && w_sel_we && !reset;

  // State register and wait counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Capture the request at the accepting edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_adr   <= 32'd0;
      r_wdata <= 32'd0;
    end else if (w_accept) begin
      r_we    <= we;
      r_adr   <= adr;
      r_wdata <= wdata;
    end
  end

  // Response data and error, updated only on RESP entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_enter) begin
      r_err <= !w_valid;
      if (!w_valid) begin
        r_rdata <= 32'd0;
      end else if (w_sel_we) begin
        r_rdata <= w_sel_wdata;
      end else begin
        r_rdata <= r_ram[w_idx];
      end
    end
  end

  // RAM write committed at RESP entry; contents survive reset
  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_ram[w_idx] <= w_sel_wdata;
    end
  end

  assign rdata = r_rdata;
  assign ready = (r_state == S_RESP);
  assign busy  = (r_state != S_IDLE);
  assign err   = r_err && (r_state == S_RESP);

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder.
// Directed table, hand sequences and a randomized model check.
module tb_mem_responder;

  localparam int W  = 2;
  localparam int DL = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we;
  logic [31:0] adr, wdata, rdata;
  logic        ready, busy, err;

  logic        req0, we0;
  logic [31:0] adr0, wdata0, rdata0;
  logic        ready0, busy0, err0;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m [64];
  bit          known [64];

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rd;
    bit          e;
  } vec_t;

  vec_t tbl [8];

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_LOG2(DL), .WAIT(W)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we),
    .adr(adr), .wdata(wdata), .rdata(rdata),
    .ready(ready), .busy(busy), .err(err)
  );

  mem_responder #(.DEPTH_LOG2(DL), .WAIT(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0),
    .adr(adr0), .wdata(wdata0), .rdata(rdata0),
    .ready(ready0), .busy(busy0), .err(err0)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: a 256-byte word memory; anything else is an error
  function automatic void model(input bit w,
                                input logic [31:0] a,
                                input logic [31:0] d,
                                output logic [31:0] rd,
                                output bit e);
    bit ok;
    int i;
    ok = (a % 4 == 0) && (a < 32'd256);
    e  = !ok;
    rd = 32'd0;
    if (ok) begin
      i = int'(a / 4);
      if (w) begin
        mem_m[i] = d;
        known[i] = 1'b1;
        rd = d;
      end else begin
        rd = mem_m[i];
      end
    end
  endfunction

  // One access on the WAIT=2 instance, entered at a negedge
  task automatic access(input bit w,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [31:0] erd,
                        input bit ee,
                        input string nm);
    req = 1'b1; we = w; adr = a; wdata = d;
    @(posedge clk);
    #1;
    req = 1'b0; we = ~w; adr = 32'hFFFF_FFFF; wdata = ~d;
    for (int k = 1; k <= W + 3; k++) begin
      @(negedge clk);
      chk({nm, " busy"}, busy, 32'(k <= W + 1));
      chk({nm, " ready"}, ready, 32'(k == W + 1));
      if (k == W + 1) begin
        chk({nm, " rdata"}, rdata, erd);
        chk({nm, " err"}, err, 32'(ee));
      end else if (k > W + 1) begin
        chk({nm, " hold"}, rdata, erd);
        chk({nm, " err0"}, err, 0);
      end
    end
  endtask

  initial begin
    logic [31:0] erd;
    bit          ee;
    logic [31:0] bb_a  [3];
    logic [31:0] bb_d  [3];
    bit          bb_w  [3];
    logic [31:0] bb_rd [3];
    bit          bb_e  [3];

    tbl[0] = '{1'b1, 32'h10,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    tbl[1] = '{1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2] = '{1'b1, 32'hFC,  32'h12345678, 32'h12345678, 1'b0};
    tbl[3] = '{1'b0, 32'hFC,  32'h0,        32'h12345678, 1'b0};
    tbl[4] = '{1'b0, 32'h100, 32'h0,        32'h0,        1'b1};
    tbl[5] = '{1'b1, 32'h0,   32'h0BADF00D, 32'h0BADF00D, 1'b0};
    tbl[6] = '{1'b1, 32'h102, 32'hFFFFFFFF, 32'h0,        1'b1};
    tbl[7] = '{1'b0, 32'h0,   32'h0,        32'h0BADF00D, 1'b0};

    for (int i = 0; i < 64; i++) begin
      known[i] = 1'b0;
      mem_m[i] = 32'd0;
    end

    reset = 1'b1;
    req = 1'b0; we = 1'b0; adr = 32'd0; wdata = 32'd0;
    req0 = 1'b0; we0 = 1'b0; adr0 = 32'd0; wdata0 = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst ready", ready, 0);
    chk("rst busy", busy, 0);
    chk("rst err", err, 0);
    chk("rst rdata", rdata, 0);
    chk("rst0 ready", ready0, 0);
    chk("rst0 busy", busy0, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      model(tbl[i].w, tbl[i].a, tbl[i].d, erd, ee);
      access(tbl[i].w, tbl[i].a, tbl[i].d,
             tbl[i].rd, tbl[i].e, $sformatf("tbl%0d", i));
    end

    // req held high: R(0), W(4), R(4) at WAIT+2 spacing
    bb_w[0] = 1'b0; bb_a[0] = 32'h0; bb_d[0] = 32'h0;
    bb_w[1] = 1'b1; bb_a[1] = 32'h4; bb_d[1] = 32'hA5A5A5A5;
    bb_w[2] = 1'b0; bb_a[2] = 32'h4; bb_d[2] = 32'h0;
    for (int i = 0; i < 3; i++)
      model(bb_w[i], bb_a[i], bb_d[i], bb_rd[i], bb_e[i]);
    req = 1'b1; we = bb_w[0]; adr = bb_a[0]; wdata = bb_d[0];
    @(posedge clk);
    #1;
    we = 1'b1; adr = 32'h4; wdata = 32'hFFFFFFFF;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("b2b busy k%0d", k), busy, 32'(k % 4 != 0));
      chk($sformatf("b2b ready k%0d", k), ready, 32'(k % 4 == 3));
      if (k % 4 == 3) begin
        chk($sformatf("b2b rdata k%0d", k), rdata, bb_rd[k / 4]);
        chk($sformatf("b2b err k%0d", k), err, 32'(bb_e[k / 4]));
      end
      if (k == 4 || k == 8) begin
        we = bb_w[k / 4]; adr = bb_a[k / 4]; wdata = bb_d[k / 4];
      end else if (k == 12) begin
        req = 1'b0;
      end else begin
        we = 1'b1; adr = 32'h4; wdata = 32'hFFFFFFFF;
      end
    end
    @(negedge clk);

    // Reset in the first WAITING cycle of a write
    model(1'b1, 32'h20, 32'h0, erd, ee);
    access(1'b1, 32'h20, 32'h0, erd, ee, "pre20");
    req = 1'b1; we = 1'b1; adr = 32'h20; wdata = 32'h1;
    @(posedge clk);
    #1;
    req = 1'b0;
    @(negedge clk);
    chk("abort busy before", busy, 1);
    reset = 1'b1;
    #1;
    chk("abort ready", ready, 0);
    chk("abort busy", busy, 0);
    chk("abort err", err, 0);
    chk("abort rdata", rdata, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("abort no ready", ready, 0);
    end
    model(1'b0, 32'h20, 32'h0, erd, ee);
    access(1'b0, 32'h20, 32'h0, erd, ee, "rd20");

    // WAIT=0 instance: write, read back, misaligned read
    for (int i = 0; i < 3; i++) begin
      logic [31:0] a0, d0, x0;
      bit w0, e0;
      w0 = (i == 0);
      a0 = (i == 2) ? 32'h3 : 32'h8;
      d0 = 32'h5A5A0001;
      x0 = (i == 2) ? 32'h0 : d0;
      e0 = (i == 2);
      req0 = 1'b1; we0 = w0; adr0 = a0; wdata0 = d0;
      @(posedge clk);
      #1;
      req0 = 1'b0; wdata0 = 32'h0;
      @(negedge clk);
      chk("w0 ready", ready0, 1);
      chk("w0 busy", busy0, 1);
      chk("w0 rdata", rdata0, x0);
      chk("w0 err", err0, 32'(e0));
      @(negedge clk);
      chk("w0 ready off", ready0, 0);
      chk("w0 busy off", busy0, 0);
    end

    // Randomized accesses against the model
    for (int n = 0; n < 40; n++) begin
      int unsigned idx, r;
      logic [31:0] a, d;
      bit w;
      idx = $urandom_range(0, 63);
      r   = $urandom_range(0, 7);
      a   = 32'(idx * 4);
      if (r == 0) a = a | 32'($urandom_range(1, 3));
      if (r == 1) a = a + 32'h100 * 32'($urandom_range(1, 1000));
      w = bit'($urandom_range(0, 1));
      if (!w && !known[idx]) w = 1'b1;
      d = $urandom;
      model(w, a, d, erd, ee);
      access(w, a, d, erd, ee, $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
